// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Single-outstanding instruction fetcher. It requests the word
//                at pc_out, holds the returned instruction until the consumer
//                retires it, then advances to next_pc. It can park in a halted
//                state, and it locks up with a sticky fault on a misaligned
//                next_pc.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc,
   output logic [31:0] pc_out,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        halt,
   output logic        fault,
   output logic [31:0] fault_pc,
   output logic [31:0] retired_count
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2,
      FAULT  = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] fault_pc_q;
   logic [31:0] count_q;
   logic        req_q;
   logic        valid_q;
   logic        fault_q;

   logic [31:0] count_d;
   logic        retire_d;
   logic        misaligned_d;

   // Retirement decode and wrapping retirement counter increment
   always_comb begin
      count_d      = count_q + 32'd1;
      retire_d     = (state_q == HOLD) && instr_ready;
      misaligned_d = (next_pc[1:0] != 2'b00);
   end

   // Fetch FSM; request/valid/fault are registered alongside the state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         instr_q    <= 32'h0000_0000;
         fault_pc_q <= 32'h0000_0000;
         count_q    <= 32'h0000_0000;
         req_q      <= 1'b1;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ack) begin
                  instr_q <= imem_rdata;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (retire_d) begin
                  pc_q    <= next_pc;
                  count_q <= count_d;
                  valid_q <= 1'b0;
                  if (misaligned_d) begin
                     fault_pc_q <= next_pc;
                     fault_q    <= 1'b1;
                     req_q      <= 1'b0;
                     state_q    <= FAULT;
                  end else if (halt) begin
                     req_q   <= 1'b0;
                     state_q <= HALTED;
                  end else begin
                     req_q   <= 1'b1;
                     state_q <= FETCH;
                  end
               end
            end
            HALTED: begin
               if (!halt) begin
                  req_q   <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FAULT: begin
               // Only reset leaves this state; everything stays frozen.
               state_q <= FAULT;
            end
            default: begin
               state_q <= FAULT;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
               fault_q <= 1'b1;
            end
         endcase
      end
   end

   assign pc_out        = pc_q;
   assign imem_req      = req_q;
   assign imem_addr     = pc_q;
   assign instr_out     = instr_q;
   assign instr_valid   = valid_q;
   assign fault         = fault_q;
   assign fault_pc      = fault_pc_q;
   assign retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Directed scenarios plus a randomized run. A memory model and
//                a consumer model drive the DUT; every accepted fetch pushes
//                the expected retirement into a queue that a separate monitor
//                drains at each observed handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] next_pc;
   logic [31:0] pc_out;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        halt;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] retired_count;

   instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .next_pc       (next_pc),
      .pc_out        (pc_out),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_out     (instr_out),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .halt          (halt),
      .fault         (fault),
      .fault_pc      (fault_pc),
      .retired_count (retired_count)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   logic        mon_en = 1'b0;
   logic [31:0] model_pc;
   logic [31:0] model_cnt;

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents as a pure function of the address
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      instr_ready = 1'b0;
      halt        = 1'b0;
      next_pc     = 32'h0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Consumer retires the held instruction, steering to nxt
   task automatic retire(input logic [31:0] nxt);
      instr_ready = 1'b1;
      next_pc     = nxt;
      step();
      instr_ready = 1'b0;
   endtask

   // Memory answers the outstanding request with data
   task automatic mem_ack(input logic [31:0] data);
      imem_ack   = 1'b1;
      imem_rdata = data;
      step();
      imem_ack   = 1'b0;
   endtask

   // Monitor: checks retirements against the scoreboard and request address
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_mis++;
               $display("FAIL sb_underflow: retirement at pc %h with empty queue", pc_out);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_pc", pc_out, e.pc);
               check("sb_instr", instr_out, e.instr);
               check("sb_count", retired_count, e.cnt);
               check("sb_fault", {31'b0, fault}, 32'd0);
            end
         end
         if (imem_req) begin
            check("mon_addr", imem_addr, model_pc);
            check("mon_valid_in_fetch", {31'b0, instr_valid}, 32'd0);
         end
      end
   end

   initial begin
      logic [31:0] p;
      logic [31:0] tgt;

      // ---------------- reset values ----------------
      do_reset();
      check("rst_pc", pc_out, RESET_PC);
      check("rst_instr", instr_out, 32'h0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_fault", {31'b0, fault}, 32'd0);
      check("rst_fault_pc", fault_pc, 32'h0);
      check("rst_count", retired_count, 32'h0);
      check("rst_req", {31'b0, imem_req}, 32'd1);
      check("rst_addr", imem_addr, RESET_PC);

      // ---------------- basic fetch ----------------
      step();
      check("bf_req", {31'b0, imem_req}, 32'd1);
      check("bf_valid_pre", {31'b0, instr_valid}, 32'd0);
      mem_ack(32'h2002_0005);
      check("bf_valid", {31'b0, instr_valid}, 32'd1);
      check("bf_instr", instr_out, 32'h2002_0005);
      check("bf_pc", pc_out, 32'h0);
      check("bf_req_off", {31'b0, imem_req}, 32'd0);

      // ---------------- sequential retire ----------------
      for (int k = 0; k < 4; k++) begin
         p = 32'(4 * k);
         retire(p + 32'd4);
         check("seq_req", {31'b0, imem_req}, 32'd1);
         check("seq_addr", imem_addr, p + 32'd4);
         check("seq_valid", {31'b0, instr_valid}, 32'd0);
         check("seq_count", retired_count, 32'(k + 1));
         if (k < 3) begin
            mem_ack(mem_f(p + 32'd4));
            check("seq_instr", instr_out, mem_f(p + 32'd4));
            check("seq_pc", pc_out, p + 32'd4);
         end
      end

      // ---------------- memory stall ----------------
      for (int k = 0; k < 5; k++) begin
         step();
         check("stall_req", {31'b0, imem_req}, 32'd1);
         check("stall_addr", imem_addr, 32'h10);
         check("stall_valid", {31'b0, instr_valid}, 32'd0);
      end
      mem_ack(32'h1111_2222);
      check("stall_done_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_done_instr", instr_out, 32'h1111_2222);

      // ---------------- branch then fault ----------------
      retire(32'h40);
      check("br_addr", imem_addr, 32'h40);
      check("br_req", {31'b0, imem_req}, 32'd1);
      mem_ack(32'h3333_4444);
      retire(32'h42);
      check("flt_fault", {31'b0, fault}, 32'd1);
      check("flt_fault_pc", fault_pc, 32'h42);
      check("flt_req", {31'b0, imem_req}, 32'd0);
      check("flt_count", retired_count, 32'd6);
      for (int k = 0; k < 4; k++) begin
         imem_ack    = 1'b1;
         instr_ready = 1'b1;
         halt        = k[0];
         next_pc     = 32'h100;
         step();
         check("flt_sticky", {31'b0, fault}, 32'd1);
         check("flt_req_hold", {31'b0, imem_req}, 32'd0);
         check("flt_valid", {31'b0, instr_valid}, 32'd0);
         check("flt_pc_frozen", pc_out, 32'h42);
         check("flt_count_frozen", retired_count, 32'd6);
         check("flt_fpc_frozen", fault_pc, 32'h42);
      end

      // ---------------- halt ----------------
      do_reset();
      mem_ack(32'h5555_6666);
      halt = 1'b1;
      retire(32'h20);
      check("halt_req", {31'b0, imem_req}, 32'd0);
      check("halt_valid", {31'b0, instr_valid}, 32'd0);
      check("halt_pc", pc_out, 32'h20);
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      check("halt_ack_ignored", {31'b0, instr_valid}, 32'd0);
      check("halt_still", {31'b0, imem_req}, 32'd0);
      halt = 1'b0;
      step();
      check("unhalt_req", {31'b0, imem_req}, 32'd1);
      check("unhalt_addr", imem_addr, 32'h20);
      halt = 1'b1;
      step();
      check("halt_in_fetch_req", {31'b0, imem_req}, 32'd1);
      mem_ack(32'hCAFE_0001);
      check("halt_in_fetch_valid", {31'b0, instr_valid}, 32'd1);
      check("halt_in_fetch_instr", instr_out, 32'hCAFE_0001);
      halt = 1'b0;
      retire(32'h24);
      check("after_halt_addr", imem_addr, 32'h24);

      // ---------------- reset mid-HOLD ----------------
      p = 32'h24;
      for (int k = 0; k < 5; k++) begin
         mem_ack(mem_f(p));
         retire(p + 32'd4);
         p = p + 32'd4;
      end
      mem_ack(mem_f(p));
      check("pre_rst_count", retired_count, 32'd7);
      check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
      rst_n      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      rst_n    = 1'b1;
      imem_ack = 1'b0;
      check("mid_rst_pc", pc_out, RESET_PC);
      check("mid_rst_count", retired_count, 32'd0);
      check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
      check("mid_rst_req", {31'b0, imem_req}, 32'd1);
      check("mid_rst_instr", instr_out, 32'h0);
      step();
      check("rst_ack_dropped", {31'b0, instr_valid}, 32'd0);
      check("rst_ack_req", {31'b0, imem_req}, 32'd1);

      // ---------------- randomized run ----------------
      do_reset();
      model_pc  = RESET_PC;
      model_cnt = 32'd0;
      sb_q.delete();
      mon_en = 1'b1;
      for (int cyc = 0; cyc < 800; cyc++) begin
         // memory side
         if (imem_req && ($urandom_range(0, 2) != 0)) begin
            exp_t e;
            e.pc    = model_pc;
            e.instr = mem_f(model_pc);
            e.cnt   = model_cnt;
            sb_q.push_back(e);
            imem_ack   = 1'b1;
            imem_rdata = mem_f(imem_addr);
         end else begin
            imem_ack   = imem_req ? 1'b0 : ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
         end
         // consumer side
         if (instr_valid && ($urandom_range(0, 1) == 1)) begin
            tgt = ($urandom_range(0, 1) == 1) ? model_pc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
            instr_ready = 1'b1;
            next_pc     = tgt;
            halt        = ($urandom_range(0, 3) == 0);
            model_pc    = tgt;
            model_cnt   = model_cnt + 32'd1;
         end else begin
            instr_ready = !instr_valid && ($urandom_range(0, 1) == 1);
            next_pc     = $urandom;
            halt        = ($urandom_range(0, 3) == 0);
         end
         step();
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b0;
      halt        = 1'b0;
      step();
      mon_en = 1'b0;
      step();
      check("rnd_final_count", retired_count, model_cnt);
      check("rnd_final_pc", pc_out, model_pc);
      check("rnd_queue_left", {31'b0, (sb_q.size() <= 1)}, 32'd1);
      check("rnd_activity", {31'b0, (model_cnt >= 32'd50)}, 32'd1);
      check("rnd_no_fault", {31'b0, fault}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-003 Port clk, input, 1: rising-edge system clock.
REQ-004 Port rst_n, input, 1: synchronous active-low reset.
REQ-005 Port next_pc, input, 32: next PC from the downstream branch/next-PC logic, computed from pc_out.
REQ-006 Port pc_out, output, 32: current PC, fed to the branch/next-PC logic.
REQ-007 Port imem_req, output, 1: instruction-memory read request.
REQ-008 Port imem_addr, output, 32: instruction-memory read address.
REQ-009 Port imem_ack, input, 1: memory read-data-valid strobe.
REQ-010 Port imem_rdata, input, 32: memory read data, valid when imem_ack=1.
REQ-011 Port instr_out, output, 32: fetched instruction word.
REQ-012 Port instr_valid, output, 1: instr_out holds a valid instruction.
REQ-013 Port instr_ready, input, 1: downstream retires the held instruction.
REQ-014 Port halt, input, 1: request to stop fetching after the current retirement.
REQ-015 Port fault, output, 1: sticky misaligned-PC fault.
REQ-016 Port fault_pc, output, 32: misaligned next_pc value that caused the fault.
REQ-017 Port retired_count, output, 32: number of retired instructions.

Function
REQ-018 The FSM SHALL have exactly four states: FETCH, HOLD, HALTED, FAULT.
REQ-019 In FETCH: imem_req=1, imem_addr=pc_out, instr_valid=0.
  - imem_ack=1: capture imem_rdata into instr_out; go to HOLD next cycle.
  - imem_ack=0: stay in FETCH with req and addr held stable.
REQ-020 Fetch latency SHALL be as follows: ack in cycle N gives instr_valid=1 in cycle N+1.
REQ-021 In HOLD: instr_valid=1, imem_req=0; instr_out and pc_out held stable.
  - instr_ready=0: stay in HOLD.
REQ-022 Retirement (HOLD and instr_ready=1) SHALL perform, at that clock edge:
  - pc_out <= next_pc;
  - retired_count <= retired_count+1, with 32-bit wrap (FFFF_FFFF -> 0);
  - next state selected per REQ-023.
REQ-023 The state after retirement SHALL be chosen by the first matching rule:
  - next_pc[1:0]!=0 -> FAULT, with fault_pc <= next_pc;
  - else halt=1 -> HALTED;
  - else -> FETCH.
REQ-024 Back-to-back timing: retirement in cycle M gives imem_req=1 with the new imem_addr in cycle M+1.
REQ-025 In HALTED: imem_req=0, instr_valid=0, pc_out held.
  - halt=0: go to FETCH next cycle.
REQ-026 In FAULT: imem_req=0, instr_valid=0, fault=1.
  - pc_out, fault_pc and retired_count frozen.
  - The block leaves FAULT only on reset.
REQ-027 The block SHALL ignore imem_ack when not in FETCH.
REQ-028 The block SHALL ignore instr_ready when not in HOLD.
REQ-029 halt SHALL be sampled only at retirement; halt asserted during FETCH SHALL NOT abort the outstanding request.
REQ-030 pc_out SHALL change only at retirement or reset.

Reset
REQ-031 With rst_n=0 at a clock edge, the block SHALL set the following on that edge, regardless of current state:
  - state=FETCH, pc_out=RESET_PC, instr_out=0;
  - instr_valid=0, fault=0, fault_pc=0, retired_count=0.
REQ-032 Reset during an outstanding fetch SHALL discard that fetch.
  - An imem_ack arriving in the reset cycle SHALL NOT be captured.
REQ-033 In the first cycle after rst_n rises: imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-034 Basic fetch: reset release, imem_ack=1 with rdata=32'h2002_0005 one cycle later -> next cycle instr_valid=1, instr_out=32'h2002_0005, pc_out=0.
REQ-035 Sequential retire: hold next_pc=pc_out+4 and ack every request immediately, instr_ready=1 -> pc_out steps 0,4,8,C; new request every 2 cycles; retired_count=4 after 4 retirements.
REQ-036 Memory stall: ack withheld for 5 cycles -> imem_req=1 and imem_addr constant for all 5 cycles; instr_valid=0 throughout.
REQ-037 Branch plus fault:
  - next_pc=32'h0000_0040 at retirement -> following imem_addr=32'h40.
  - then next_pc=32'h0000_0042 -> fault=1, fault_pc=32'h42, imem_req stays 0 until reset.
REQ-038 Halt: halt=1 at a retirement -> HALTED, no request.
  - Release halt -> imem_req=1 one cycle later at the updated pc_out.
REQ-039 Reset mid-HOLD with retired_count=7 -> next cycle pc_out=RESET_PC, retired_count=0, instr_valid=0, imem_req=1.
